// File: rtl/player_pkg.sv
// Shared types and LED-grid defaults for the player motion slice.
// State encoding also covers HANG, used only when PLAYER_HANG_TIME_EN is set.
package player_pkg;

  localparam int PV_ROWS      = 16;
  localparam int PV_Y_W       = 4;
  localparam int PV_START_ROW = 14;
  localparam int PV_MAX_RISE  = 4;

  typedef enum logic [2:0] {
    ST_GROUND = 3'd0,
    ST_RISE   = 3'd1,
    ST_FALL   = 3'd2,
    ST_HANG   = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  function automatic logic is_airborne(
    input state_t s
  );
    return (s == ST_RISE) ||
           (s == ST_FALL) ||
           (s == ST_HANG);
  endfunction

endpackage

// File: rtl/player_vertical_motion.sv
// Jump level + column floor map -> player row; moves only on step.
// Define PLAYER_HANG_TIME_EN to add a one-step HANG at the jump apex.
module player_vertical_motion
  import player_pkg::*;
#(
  parameter int ROWS      = PV_ROWS,
  parameter int Y_W       = PV_Y_W,
  parameter int START_ROW = PV_START_ROW,
  parameter int MAX_RISE  = PV_MAX_RISE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step,
  input  logic            jump,
  input  logic [ROWS-1:0] floor_map,
  output logic [Y_W-1:0]  y,
  output logic            on_platform,
  output logic            airborne,
  output logic            fell_off
);

  localparam int CW = $clog2(MAX_RISE + 1);

  localparam logic [Y_W-1:0] LAST_Y = Y_W'(ROWS - 1);
  localparam logic [Y_W-1:0] RST_Y  = Y_W'(START_ROW);
  localparam logic [Y_W-1:0] ONE_Y  = Y_W'(1);
  localparam logic [Y_W:0]   ONE_YX = (Y_W+1)'(1);
  localparam logic [CW-1:0]  MAX_C  = CW'(MAX_RISE);
  localparam logic [CW-1:0]  ONE_C  = CW'(1);
  localparam logic [ROWS-1:0] BIT0  = ROWS'(1);

`ifdef PLAYER_HANG_TIME_EN
  localparam state_t RISE_EXIT = ST_HANG;
`else
  localparam state_t RISE_EXIT = ST_FALL;
`endif

  state_t         r_state;
  logic [Y_W-1:0] r_y;
  logic [CW-1:0]  r_cnt;
  logic           r_on;
  logic           r_air;
  logic           r_fell;

  logic [Y_W:0]    w_y_inc;
  logic [ROWS-1:0] w_mask;
  logic            w_at_top;
  logic            w_at_bot;
  logic            w_floor_below;
  logic            w_can_rise;

  state_t         w_state_nx;
  logic [Y_W-1:0] w_y_nx;
  logic [CW-1:0]  w_cnt_nx;

  // y+1 one bit wider so the bottom row never wraps to row 0
  assign w_y_inc  = {1'b0, r_y} + ONE_YX;
  assign w_mask   = BIT0 << w_y_inc;
  assign w_at_top = (r_y == '0);
  assign w_at_bot = (r_y == LAST_Y);

  assign w_floor_below =
    !w_at_bot && (|(floor_map & w_mask));

  assign w_can_rise =
    jump && (r_cnt < MAX_C) && !w_at_top;

  always_comb begin
    w_state_nx = r_state;
    w_y_nx     = r_y;
    w_cnt_nx   = r_cnt;
    if (step) begin
      unique case (r_state)
        ST_GROUND: begin
          if (jump && !w_at_top) begin
            w_state_nx = ST_RISE;
            w_y_nx     = r_y - ONE_Y;
            w_cnt_nx   = ONE_C;
          end else if (!w_floor_below) begin
            w_state_nx = ST_FALL;
          end
        end
        ST_RISE: begin
          if (w_can_rise) begin
            w_y_nx   = r_y - ONE_Y;
            w_cnt_nx = r_cnt + ONE_C;
          end else begin
            w_state_nx = RISE_EXIT;
            w_cnt_nx   = '0;
          end
        end
        ST_FALL: begin
          if (w_floor_below) begin
            w_state_nx = ST_GROUND;
          end else if (w_at_bot) begin
            w_state_nx = ST_OUT;
          end else begin
            w_y_nx = r_y + ONE_Y;
          end
        end
`ifdef PLAYER_HANG_TIME_EN
        ST_HANG: begin
          w_state_nx = ST_FALL;
        end
`endif
        ST_OUT: begin
          w_state_nx = ST_OUT;
        end
        default: begin
          w_state_nx = ST_FALL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_GROUND;
      r_y     <= RST_Y;
      r_cnt   <= '0;
      r_on    <= 1'b1;
      r_air   <= 1'b0;
      r_fell  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_y     <= w_y_nx;
      r_cnt   <= w_cnt_nx;
      r_on    <= (w_state_nx == ST_GROUND);
      r_air   <= is_airborne(w_state_nx);
      r_fell  <= (w_state_nx == ST_OUT);
    end
  end

  assign y           = r_y;
  assign on_platform = r_on;
  assign airborne    = r_air;
  assign fell_off    = r_fell;

endmodule

// File: tb/tb_player_vertical_motion.sv
// Directed bench for player_vertical_motion: ground, jumps, falls,
// ceiling bump, fall-off and reset recovery.
module tb_player_vertical_motion;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] floor_map = 16'h8000;
  logic [3:0]  y;
  logic        on_platform, airborne, fell_off;

  logic        step2 = 1'b0;
  logic        jump2 = 1'b0;
  logic [15:0] floor2 = 16'h0008;
  logic [3:0]  y2;
  logic        onp2, air2, fell2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  player_vertical_motion u_dut (
    .clk(clk), .reset(reset), .step(step), .jump(jump),
    .floor_map(floor_map), .y(y), .on_platform(on_platform),
    .airborne(airborne), .fell_off(fell_off)
  );

  player_vertical_motion #(.START_ROW(2)) u_ceil (
    .clk(clk), .reset(reset), .step(step2), .jump(jump2),
    .floor_map(floor2), .y(y2), .on_platform(onp2),
    .airborne(air2), .fell_off(fell2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input int ey, input bit eo,
                      input bit ea, input bit ef);
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".onp"}, 32'(on_platform), 32'(eo));
    chk({tag, ".air"}, 32'(airborne), 32'(ea));
    chk({tag, ".fell"}, 32'(fell_off), 32'(ef));
  endtask

  task automatic pulse(input bit j);
    @(negedge clk);
    step = 1'b1;
    jump = j;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic pulse2(input bit j);
    @(negedge clk);
    step2 = 1'b1;
    jump2 = j;
    @(negedge clk);
    step2 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // 1: reset, idle steps, step held low
    do_reset();
    chk1("rst", 14, 1, 0, 0);
    chk("rst.y2", 32'(y2), 32'd2);
    for (int i = 0; i < 10; i++) pulse(1'b0);
    chk1("idle10", 14, 1, 0, 0);
    jump = 1'b1;
    repeat (20) @(negedge clk);
    chk1("nostep", 14, 1, 0, 0);
    jump = 1'b0;

    // 2: full jump with apex, descent, landing
    pulse(1'b1); chk1("j1", 13, 0, 1, 0);
    pulse(1'b1); chk1("j2", 12, 0, 1, 0);
    jump = 1'b1;
    repeat (5) @(negedge clk);
    chk1("j2hold", 12, 0, 1, 0);
    pulse(1'b1); chk1("j3", 11, 0, 1, 0);
    pulse(1'b1); chk1("j4", 10, 0, 1, 0);
    pulse(1'b1); chk1("apex", 10, 0, 1, 0);
`ifdef PLAYER_HANG_TIME_EN
    pulse(1'b0); chk1("hang", 10, 0, 1, 0);
`endif
    pulse(1'b0); chk1("f11", 11, 0, 1, 0);
    pulse(1'b1); chk1("f12", 12, 0, 1, 0);
    pulse(1'b0); chk1("f13", 13, 0, 1, 0);
    pulse(1'b0); chk1("f14", 14, 0, 1, 0);
    pulse(1'b0); chk1("land", 14, 1, 0, 0);

    // 3: short hop released early
    pulse(1'b1); chk1("h1", 13, 0, 1, 0);
    pulse(1'b1); chk1("h2", 12, 0, 1, 0);
    pulse(1'b0); chk1("hrel", 12, 0, 1, 0);
`ifdef PLAYER_HANG_TIME_EN
    pulse(1'b0); chk1("hhang", 12, 0, 1, 0);
`endif
    pulse(1'b0); chk1("hf13", 13, 0, 1, 0);
    pulse(1'b0); chk1("hf14", 14, 0, 1, 0);
    pulse(1'b0); chk1("hland", 14, 1, 0, 0);

    // 4: floor removed, fall through bottom row
    floor_map = 16'h0000;
    pulse(1'b0); chk1("drop", 14, 0, 1, 0);
    pulse(1'b0); chk1("d15", 15, 0, 1, 0);
    pulse(1'b0); chk1("out", 15, 0, 0, 1);
    pulse(1'b1); chk1("outj", 15, 0, 0, 1);
    floor_map = 16'h8000;
    pulse(1'b0); chk1("outsty", 15, 0, 0, 1);
    do_reset();
    chk1("rst2", 14, 1, 0, 0);

    // 5: ceiling at row 0 on the START_ROW=2 instance
    pulse2(1'b1); chk("c1", 32'(y2), 32'd1);
    pulse2(1'b1); chk("c0", 32'(y2), 32'd0);
    chk("c0.air", 32'(air2), 32'd1);
    pulse2(1'b1); chk("ctop", 32'(y2), 32'd0);
`ifdef PLAYER_HANG_TIME_EN
    pulse2(1'b1); chk("chang", 32'(y2), 32'd0);
`endif
    pulse2(1'b1); chk("cf1", 32'(y2), 32'd1);
    pulse2(1'b0); chk("cf2", 32'(y2), 32'd2);
    chk("cf2.onp", 32'(onp2), 32'd0);
    pulse2(1'b0); chk("cland", 32'(y2), 32'd2);
    chk("cland.onp", 32'(onp2), 32'd1);
    chk("cland.air", 32'(air2), 32'd0);
    pulse2(1'b1); chk("cj", 32'(y2), 32'd1);
    chk1("u1idle", 14, 1, 0, 0);

    // 6: reset mid-rise clears the rise counter
    pulse(1'b1); pulse(1'b1); pulse(1'b1);
    chk1("mid", 11, 0, 1, 0);
    do_reset();
    chk1("rstmid", 14, 1, 0, 0);
    pulse(1'b1); chk1("r1", 13, 0, 1, 0);
    pulse(1'b1); chk1("r2", 12, 0, 1, 0);
    pulse(1'b1); chk1("r3", 11, 0, 1, 0);
    pulse(1'b1); chk1("r4", 10, 0, 1, 0);
    pulse(1'b1); chk1("rapex", 10, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
